// File: rtl/pcap_framer_if.sv
// Signal bundle between the pcap framer, its packet FIFO, the start/timestamp source
// and the downstream write controller.
interface pcap_framer_if;
  logic        start;
  logic [15:0] pkt_len;
  logic [31:0] seconds;
  logic [31:0] nanoseconds;
  logic        fifo_empty;
  logic [31:0] fifo_q;
  logic        fifo_rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        busy;
  logic        done;
  logic [31:0] rec_count;

  modport master (
    input  start, pkt_len, seconds, nanoseconds, fifo_empty, fifo_q, out_ready,
    output fifo_rd, out_data, out_valid, out_sop, out_eop, busy, done, rec_count
  );

  modport slave (
    output start, pkt_len, seconds, nanoseconds, fifo_empty, fifo_q, out_ready,
    input  fifo_rd, out_data, out_valid, out_sop, out_eop, busy, done, rec_count
  );
endinterface

// File: rtl/pcap_framer.sv
// Frames one packet as a pcap record: four header words, the payload truncated to
// SNAPLEN, then silent draining of the untaken payload words from the FIFO.
//
// state   | meaning
// IDLE    | waiting for start; fields latched on start
// HDR0    | seconds word (sop)
// HDR1    | nanoseconds word
// HDR2    | incl_len word
// HDR3    | orig_len word (eop when no payload)
// PAYLOAD | forwarding incl_words FIFO words, last one lane-masked
// DRAIN   | popping the orig_words - incl_words words that were not captured
// FIN     | one-cycle done pulse, record counter bump
module pcap_framer #(
  parameter logic [15:0] SNAPLEN = 16'd1518
) (
  input  logic         clk,
  input  logic         reset,
  pcap_framer_if.master io
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, HDR3, PAYLOAD, DRAIN, FIN} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_sec, r_ns, r_rec_count;
  logic [15:0] r_pkt_len, r_incl_len, r_incl_words, r_orig_words, r_cnt;
  logic [15:0] w_incl_len, w_incl_words, w_orig_words, w_drain_words;
  logic [31:0] w_last_mask, w_data;
  logic        w_valid, w_sop, w_eop, w_rd, w_xfer, w_last;

  assign w_incl_len    = (io.pkt_len > SNAPLEN) ? SNAPLEN : io.pkt_len;
  assign w_incl_words  = {2'b00, w_incl_len[15:2]} + {15'd0, |w_incl_len[1:0]};
  assign w_orig_words  = {2'b00, io.pkt_len[15:2]} + {15'd0, |io.pkt_len[1:0]};
  assign w_drain_words = r_orig_words - r_incl_words;
  assign w_last        = (r_cnt == 16'd1);
  assign w_xfer        = w_valid && io.out_ready;

  // A remainder of zero means the last word is fully populated.
  always_comb begin
    case (r_incl_len[1:0])
      2'd1:    w_last_mask = 32'h0000_00FF;
      2'd2:    w_last_mask = 32'h0000_FFFF;
      2'd3:    w_last_mask = 32'h00FF_FFFF;
      default: w_last_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_data  = 32'h0;
    w_sop   = 1'b0;
    w_eop   = 1'b0;
    w_rd    = 1'b0;
    case (r_state)
      IDLE: if (io.start) w_next = HDR0;
      HDR0: begin
        w_valid = 1'b1;
        w_sop   = 1'b1;
        w_data  = r_sec;
        if (io.out_ready) w_next = HDR1;
      end
      HDR1: begin
        w_valid = 1'b1;
        w_data  = r_ns;
        if (io.out_ready) w_next = HDR2;
      end
      HDR2: begin
        w_valid = 1'b1;
        w_data  = {16'h0, r_incl_len};
        if (io.out_ready) w_next = HDR3;
      end
      HDR3: begin
        w_valid = 1'b1;
        w_data  = {16'h0, r_pkt_len};
        w_eop   = (r_incl_words == 16'd0);
        if (io.out_ready) begin
          if (r_incl_words != 16'd0)      w_next = PAYLOAD;
          else if (r_orig_words != 16'd0) w_next = DRAIN;
          else                            w_next = FIN;
        end
      end
      PAYLOAD: begin
        w_valid = !io.fifo_empty;
        w_data  = w_last ? (io.fifo_q & w_last_mask) : io.fifo_q;
        w_eop   = w_last;
        w_rd    = w_valid && io.out_ready;
        if (w_rd && w_last) w_next = (w_drain_words != 16'd0) ? DRAIN : FIN;
      end
      DRAIN: begin
        w_rd = !io.fifo_empty;
        if (w_rd && w_last) w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sec        <= 32'h0;
      r_ns         <= 32'h0;
      r_pkt_len    <= 16'h0;
      r_incl_len   <= 16'h0;
      r_incl_words <= 16'h0;
      r_orig_words <= 16'h0;
      r_cnt        <= 16'h0;
      r_rec_count  <= 32'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (io.start) begin
          r_sec        <= io.seconds;
          r_ns         <= io.nanoseconds;
          r_pkt_len    <= io.pkt_len;
          r_incl_len   <= w_incl_len;
          r_incl_words <= w_incl_words;
          r_orig_words <= w_orig_words;
        end
        // The same down-counter serves payload then drain; it is reloaded between phases.
        HDR3:    if (w_xfer) r_cnt <= (r_incl_words != 16'd0) ? r_incl_words : r_orig_words;
        PAYLOAD: if (w_rd) r_cnt <= w_last ? w_drain_words : r_cnt - 16'd1;
        DRAIN:   if (w_rd) r_cnt <= r_cnt - 16'd1;
        FIN:     r_rec_count <= r_rec_count + 32'd1;
        default: ;
      endcase
    end
  end

  assign io.out_valid = w_valid;
  assign io.out_data  = w_data;
  assign io.out_sop   = w_sop;
  assign io.out_eop   = w_eop;
  assign io.fifo_rd   = w_rd;
  assign io.busy      = (r_state != IDLE);
  assign io.done      = (r_state == FIN);
  assign io.rec_count = r_rec_count;

endmodule

// File: tb/tb_pcap_framer.sv
// Bench for pcap_framer: table of records driven against a FIFO model, expected
// words queued per record and compared as the framer emits them.
module tb_pcap_framer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pcap_framer_if io ();
  pcap_framer dut (.clk(clk), .reset(reset), .io(io));

  typedef struct {
    logic [15:0] pkt_len;
    logic [31:0] sec;
    logic [31:0] ns;
    logic [31:0] special;
    bit          stall;
    int          exp_words;
    logic [15:0] exp_incl;
  } vec_t;

  vec_t        vecs [9];
  logic [33:0] exp_q [$];
  logic [31:0] fifo_m [$];
  int n_pass = 0, n_total = 0;
  int n_done, n_words, n_sop, n_eop, viol_pop, viol_stable;
  int rec_exp = 0;
  bit stall_mode = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_bus();
    io.out_ready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    io.fifo_empty = (fifo_m.size() == 0) || (stall_mode && ($urandom_range(0, 3) == 0));
    io.fifo_q     = (fifo_m.size() > 0) ? fifo_m[0] : 32'h0;
  endtask

  task automatic monitor();
    logic [33:0] e;
    if (io.done) n_done++;
    if (io.fifo_rd && (io.fifo_empty || !io.busy)) viol_pop++;
    if (prev_stall && io.out_valid && io.out_data !== prev_data) viol_stable++;
    prev_stall = io.out_valid && !io.out_ready;
    prev_data  = io.out_data;
    if (io.out_valid && io.out_ready) begin
      n_words++;
      if (io.out_sop) n_sop++;
      if (io.out_eop) n_eop++;
      if (exp_q.size() == 0) check("extra_word", 64'(io.out_data), 64'hDEAD);
      else begin
        e = exp_q.pop_front();
        check($sformatf("word%0d{sop,eop,data}", n_words - 1),
              64'({io.out_sop, io.out_eop, io.out_data}), 64'(e));
      end
    end
  endtask

  task automatic step();
    logic pop;
    @(negedge clk);
    monitor();
    pop = io.fifo_rd;
    @(posedge clk);
    if (pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
    #1;
    drive_bus();
  endtask

  // Builds the FIFO contents and the expected record for one vector.
  task automatic setup(input vec_t v, input int idx);
    int iw, ow, incl;
    logic [31:0] w;
    logic [31:0] fw [$];
    incl = int'(v.exp_incl);
    iw = (incl + 3) / 4;
    ow = (int'(v.pkt_len) + 3) / 4;
    for (int k = 0; k < ow; k++)
      fw.push_back((k == 1 && v.special != 0) ? v.special : {8'(idx), 8'hA5, 16'(k)});
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, v.sec});
    exp_q.push_back({1'b0, 1'b0, v.ns});
    exp_q.push_back({1'b0, 1'b0, 16'h0, v.exp_incl});
    exp_q.push_back({1'b0, (iw == 0), 16'h0, v.pkt_len});
    for (int k = 0; k < iw; k++) begin
      w = fw[k];
      if (k == iw - 1)
        for (int b = 0; b < 4; b++)
          if (k * 4 + b >= incl) w[b*8 +: 8] = 8'h00;
      exp_q.push_back({1'b0, (k == iw - 1), w});
    end
    fifo_m = fw;
    stall_mode = v.stall;
    n_done = 0; n_words = 0; n_sop = 0; n_eop = 0; viol_pop = 0; viol_stable = 0;
    prev_stall = 0;
    drive_bus();
    io.start = 1'b1;
    io.pkt_len = v.pkt_len;
    io.seconds = v.sec;
    io.nanoseconds = v.ns;
    step();
    io.start = 1'b0;
  endtask

  task automatic run_record(input vec_t v, input int idx);
    int cyc;
    setup(v, idx);
    cyc = 0;
    while (n_done == 0 && cyc < 4000) begin
      if (v.stall && cyc == 5) begin
        io.start = 1'b1;
        io.pkt_len = 16'd99;
      end else io.start = 1'b0;
      step();
      cyc++;
    end
    io.start = 1'b0;
    step();
    rec_exp++;
    check($sformatf("r%0d done_pulses", idx), 64'(n_done), 64'd1);
    check($sformatf("r%0d words", idx), 64'(n_words), 64'(v.exp_words));
    check($sformatf("r%0d exp_left", idx), 64'(exp_q.size()), 64'd0);
    check($sformatf("r%0d sop_eop", idx), 64'({n_sop[7:0], n_eop[7:0]}), 64'h0101);
    check($sformatf("r%0d fifo_left", idx), 64'(fifo_m.size()), 64'd0);
    check($sformatf("r%0d bad_pops", idx), 64'(viol_pop), 64'd0);
    check($sformatf("r%0d stall_unstable", idx), 64'(viol_stable), 64'd0);
    check($sformatf("r%0d busy_after", idx), 64'(io.busy), 64'd0);
    check($sformatf("r%0d rec_count", idx), 64'(io.rec_count), 64'(rec_exp));
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'd8,    32'h6000_0001, 32'h0000_0100, 32'h0,         1'b0, 6,   16'd8};
    vecs[1] = '{16'd6,    32'h6000_0002, 32'h0000_0200, 32'hAABB_CCDD, 1'b0, 6,   16'd6};
    vecs[2] = '{16'd1525, 32'h6000_0003, 32'h0000_0300, 32'h0,         1'b0, 384, 16'd1518};
    vecs[3] = '{16'd0,    32'h6000_0004, 32'h0000_0400, 32'h0,         1'b0, 4,   16'd0};
    vecs[4] = '{16'd13,   32'h6000_0005, 32'h0000_0500, 32'h1234_5678, 1'b1, 8,   16'd13};
    vecs[5] = '{16'd1530, 32'h6000_0006, 32'h0000_0600, 32'h0,         1'b1, 384, 16'd1518};
    vecs[6] = '{16'd1518, 32'h6000_0007, 32'h0000_0700, 32'h0,         1'b0, 384, 16'd1518};
    vecs[7] = '{16'd1519, 32'h6000_0008, 32'h0000_0800, 32'h0,         1'b0, 384, 16'd1518};
    vecs[8] = '{16'd4,    32'h6000_0009, 32'h0000_0900, 32'h0,         1'b1, 5,   16'd4};

    reset = 1'b0;
    io.start = 1'b0; io.pkt_len = 16'h0; io.seconds = 32'h0; io.nanoseconds = 32'h0;
    io.out_ready = 1'b1; io.fifo_empty = 1'b1; io.fifo_q = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl{valid,rd,sop,eop,busy,done}",
          64'({io.out_valid, io.fifo_rd, io.out_sop, io.out_eop, io.busy, io.done}), 64'h0);
    check("reset_rec_count", 64'(io.rec_count), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_record(vecs[i], i);

    // Reset landing mid-payload: the record is abandoned silently.
    setup('{16'd40, 32'h7000_0001, 32'h0000_0A00, 32'h0, 1'b0, 14, 16'd40}, 20);
    cyc = 0;
    while (n_words < 6 && cyc < 200) begin step(); cyc++; end
    check("pre_reset_words", 64'(n_words), 64'd6);
    check("pre_reset_busy", 64'(io.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midrec_reset_ctrl{valid,rd,sop,eop,busy,done}",
          64'({io.out_valid, io.fifo_rd, io.out_sop, io.out_eop, io.busy, io.done}), 64'h0);
    check("midrec_reset_rec_count", 64'(io.rec_count), 64'h0);
    repeat (3) step();
    reset = 1'b1;
    repeat (4) step();
    check("post_reset_done", 64'(n_done), 64'd0);
    check("post_reset_rec_count", 64'(io.rec_count), 64'd0);
    check("post_reset_busy", 64'(io.busy), 64'd0);
    fifo_m.delete();
    rec_exp = 0;
    run_record(vecs[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcap_framer.md
PCAP_FRAMER -- requirements
Module: pcap_framer

Interface
REQ-001 SHALL have parameter SNAPLEN, default 16'd1518, maximum captured bytes per record.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse: frame one packet.
REQ-005 SHALL have port pkt_len  input  16  original packet length in bytes, sampled on accepted start.
REQ-006 SHALL have port seconds  input  32  timestamp seconds, sampled on accepted start.
REQ-007 SHALL have port nanoseconds  input  32  timestamp nanoseconds, sampled on accepted start.
REQ-008 SHALL have port fifo_empty  input  1  packet FIFO empty.
REQ-009 SHALL have port fifo_q  input  32  show-ahead FIFO head word, valid while !fifo_empty.
REQ-010 SHALL have port fifo_rd  output  1  pop FIFO head this cycle.
REQ-011 SHALL have port out_data  output  32  framed record word to the write controller.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts word.
REQ-014 SHALL have port out_sop / out_eop  output  1 each  first / last word of record.
REQ-015 SHALL have port busy  output  1  record in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at record completion.
REQ-017 SHALL have port rec_count  output  32  completed records, wraps modulo 2^32.

Function
REQ-018 SHALL implement FSM states IDLE, HDR0, HDR1, HDR2, HDR3, PAYLOAD, DRAIN, FIN.
REQ-019 IDLE: start SHALL latch pkt_len, seconds, nanoseconds, compute incl_len = min(pkt_len, SNAPLEN), go to HDR0 next cycle; start outside IDLE SHALL be ignored.
REQ-020 HDR0..HDR3 SHALL present out_valid=1 with out_data = seconds, nanoseconds, {16'h0,incl_len}, {16'h0,pkt_len} respectively; out_sop=1 in HDR0 only.
REQ-021 Each header state SHALL advance only on out_valid&&out_ready; out_data SHALL stay stable while out_valid&&!out_ready.
REQ-022 Payload word counts: incl_words = ceil(incl_len/4), orig_words = ceil(pkt_len/4), 16-bit arithmetic, no overflow for pkt_len ≤ 65535.
REQ-023 HDR3 SHALL go to PAYLOAD if incl_words>0, else DRAIN if orig_words>0, else FIN; out_eop=1 in HDR3 iff incl_words==0.
REQ-024 PAYLOAD: out_valid = !fifo_empty; fifo_rd = out_valid&&out_ready (combinational); out_data = fifo_q with byte lanes beyond incl_len zeroed on last word (byte 0 = bits [7:0]).
REQ-025 PAYLOAD: out_eop=1 on last word (incl_words-th); after its transfer SHALL go to DRAIN if orig_words>incl_words, else FIN.
REQ-026 DRAIN: out_valid=0; fifo_rd = !fifo_empty; after orig_words-incl_words pops SHALL go to FIN.
REQ-027 FIN: done=1 for exactly one cycle, rec_count += 1, then IDLE; busy=0 only in IDLE.
REQ-028 fifo_rd SHALL never assert while fifo_empty=1, nor outside PAYLOAD/DRAIN.
REQ-029 Exactly 4+incl_words words SHALL be transferred per record; one sop and one eop each.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, out_valid=0, fifo_rd=0, out_sop=0, out_eop=0, busy=0, done=0, rec_count=0, all latched fields 0.
REQ-031 Reset mid-record SHALL abandon the record with no done pulse and no rec_count increment; FIFO contents are not flushed by this block.
REQ-032 Outputs SHALL be glitch-free on reset release; first start accepted is the first sampled in IDLE after release.

Verification
REQ-033 pkt_len=8, SNAPLEN=1518, out_ready=1, FIFO holds 2 words -> 6 words: sec, ns, 8, 8, w0, w1; sop on word0, eop on w1; done once; rec_count=1.
REQ-034 pkt_len=6, FIFO word1=32'hAABBCCDD -> last payload word 32'h0000CCDD, incl_len=orig_len=6.
REQ-035 SNAPLEN=8, pkt_len=20, FIFO holds 5 words -> header incl=8 orig=20, 2 payload words output, 3 words drained, FIFO empty at done.
REQ-036 pkt_len=0 -> 4 header words only, eop on HDR3, no fifo_rd, done pulse.
REQ-037 Random out_ready stalls and fifo_empty gaps -> out_data stable during stall, no pop while empty, word sequence identical to no-stall run; start pulses while busy ignored.
REQ-038 reset asserted during PAYLOAD -> all outputs reset values same cycle, no done, rec_count unchanged at 0 after release.
